// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight writers, raises a registered stall and
// (when HAZARD_FWD_EN is defined) selects forwarding sources for rs/rt.
module hazard_scoreboard #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_in,
  input  logic             instr_valid,
  input  logic             flush,
  output logic             stall_out,
  output logic [3:0]       fwd_rs_sel,
  output logic [3:0]       fwd_rt_sel,
  output logic [CNT_W-1:0] stall_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [5:0] opcode;
  logic [4:0] rs, rt, rd;
  assign opcode = instr_in[31:26];
  assign rs     = instr_in[25:21];
  assign rt     = instr_in[20:16];
  assign rd     = instr_in[15:11];

  logic       reads_rs, reads_rt, is_load;
  logic [4:0] dest;

  always_comb begin
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    is_load  = 1'b0;
    dest     = 5'd0;
    if (opcode[5:3] == 3'b001) begin
      reads_rs = 1'b1;
      dest     = rt;
    end else if (opcode[5:3] == 3'b100) begin
      reads_rs = 1'b1;
      dest     = rt;
      is_load  = 1'b1;
    end else if (opcode[5:2] == 4'b1010 || opcode[5:1] == 5'b00010) begin
      reads_rs = 1'b1;
      reads_rt = 1'b1;
    end else if (opcode[5:1] == 5'b00011 || opcode == 6'b000001) begin
      reads_rs = 1'b1;
    end else if (opcode == 6'b000000) begin
      reads_rs = 1'b1;
      reads_rt = 1'b1;
      dest     = rd;
    end else if (opcode == 6'b000011) begin
      dest     = 5'd31;
    end
  end

  logic [DEPTH-1:0][4:0] slot_dest;
  logic [DEPTH-1:0]      slot_load;

  logic       rs_hit, rt_hit;
  logic [3:0] rs_idx, rt_idx;

  // Walk oldest to youngest so the lowest matching index wins.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    rs_idx = 4'd0;
    rt_idx = 4'd0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (reads_rs && rs != 5'd0 && rs == slot_dest[k]) begin
        rs_hit = 1'b1;
        rs_idx = 4'(k);
      end
      if (reads_rt && rt != 5'd0 && rt == slot_dest[k]) begin
        rt_hit = 1'b1;
        rt_idx = 4'(k);
      end
    end
  end

  logic rs_stall, rt_stall, live, stall;
  logic unused_sink;

`ifdef HAZARD_FWD_EN
  assign rs_stall    = rs_hit && rs_idx == 4'd0 && slot_load[0];
  assign rt_stall    = rt_hit && rt_idx == 4'd0 && slot_load[0];
  assign unused_sink = ^{instr_in[10:0], slot_load};
`else
  assign rs_stall    = rs_hit;
  assign rt_stall    = rt_hit;
  assign unused_sink = ^{instr_in[10:0], slot_load, rs_idx, rt_idx};
`endif

  assign live  = instr_valid && !flush;
  assign stall = live && (rs_stall || rt_stall);

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_dest   <= '0;
      slot_load   <= '0;
      stall_out   <= 1'b0;
      stall_count <= '0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        slot_dest[k] <= slot_dest[k-1];
        slot_load[k] <= slot_load[k-1];
      end
      slot_dest[0] <= (live && !stall) ? dest : 5'd0;
      slot_load[0] <= live && !stall && is_load;
      stall_out    <= stall;
      stall_count  <= stall_out ? sat_inc(stall_count) : stall_count;
    end
  end

`ifdef HAZARD_FWD_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_rs_sel <= 4'd0;
      fwd_rt_sel <= 4'd0;
    end else begin
      fwd_rs_sel <= (live && !stall && rs_hit) ? rs_idx + 4'd1 : 4'd0;
      fwd_rt_sel <= (live && !stall && rt_hit) ? rt_idx + 4'd1 : 4'd0;
    end
  end
`else
  assign fwd_rs_sel = 4'd0;
  assign fwd_rt_sel = 4'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; covers the default mode, or the forwarding mode
// when HAZARD_FWD_EN is defined.
module tb_hazard_scoreboard;

  localparam logic [31:0] ADD3  = 32'h0022_1820; // add $3,$1,$2
  localparam logic [31:0] SUB4  = 32'h0065_2022; // sub $4,$3,$5
  localparam logic [31:0] ADDI0 = 32'h2020_0005; // addi $0,$1,5
  localparam logic [31:0] ADD6  = 32'h0000_3020; // add $6,$0,$0
  localparam logic [31:0] LW8   = 32'h8D28_0000; // lw $8,0($9)
  localparam logic [31:0] ADD10 = 32'h0108_5020; // add $10,$8,$8
  localparam logic [31:0] BEQ34 = 32'h1064_0000; // beq $3,$4
  localparam logic [31:0] JAL   = 32'h0C00_0000; // jal
  localparam logic [31:0] JR31  = 32'h03E0_0008; // jr $31

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_in = 32'd0;
  logic        instr_valid = 1'b0;
  logic        flush = 1'b0;
  logic        stall_out;
  logic [3:0]  fwd_rs_sel, fwd_rt_sel;
  logic [3:0]  stall_count;

  int n_cmp = 0;
  int n_err = 0;

  hazard_scoreboard #(.DEPTH(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .flush(flush), .stall_out(stall_out), .fwd_rs_sel(fwd_rs_sel),
    .fwd_rt_sel(fwd_rt_sel), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [31:0] i, input logic v, input logic f);
    instr_in = i;
    instr_valid = v;
    flush = f;
    @(posedge clk);
    #1;
  endtask

  task automatic bubbles();
    cyc(32'd0, 1'b0, 1'b0);
    cyc(32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    cyc(32'd0, 1'b0, 1'b0);
    cyc(32'd0, 1'b0, 1'b0);
    reset = 1'b0;
    chk("rst_stall", stall_out, 0);
    chk("rst_cnt", stall_count, 0);
    chk("rst_fwd_rs", fwd_rs_sel, 0);
    chk("rst_fwd_rt", fwd_rt_sel, 0);
    chk("rst_slot0", dut.slot_dest[0], 0);

`ifndef HAZARD_FWD_EN
    cyc(ADD3, 1'b1, 1'b0);
    chk("raw_pre", stall_out, 0);
    cyc(SUB4, 1'b1, 1'b0);
    chk("raw_st1", stall_out, 1);
    cyc(SUB4, 1'b1, 1'b0);
    chk("raw_st2", stall_out, 1);
    cyc(SUB4, 1'b1, 1'b0);
    chk("raw_rel", stall_out, 0);
    chk("raw_cnt", stall_count, 2);
    chk("raw_slot0", dut.slot_dest[0], 4);

    bubbles();
    cyc(ADD3, 1'b1, 1'b0);
    cyc(SUB4, 1'b0, 1'b0);
    chk("invalid_nostall", stall_out, 0);

    bubbles();
    cyc(ADDI0, 1'b1, 1'b0);
    chk("r0_slot0", dut.slot_dest[0], 0);
    cyc(ADD6, 1'b1, 1'b0);
    chk("r0_nostall", stall_out, 0);
    cyc(ADD6, 1'b1, 1'b0);
    chk("r0_nostall2", stall_out, 0);

    bubbles();
    cyc(JAL, 1'b1, 1'b0);
    chk("jal_slot0", dut.slot_dest[0], 31);
    cyc(JR31, 1'b1, 1'b0);
    chk("jr_st1", stall_out, 1);
    cyc(JR31, 1'b1, 1'b0);
    chk("jr_st2", stall_out, 1);
    cyc(JR31, 1'b1, 1'b0);
    chk("jr_rel", stall_out, 0);
    chk("jr_cnt", stall_count, 4);

    bubbles();
    cyc(JAL, 1'b1, 1'b0);
    cyc(JR31, 1'b1, 1'b1);
    chk("flush_stall", stall_out, 0);
    chk("flush_slot0", dut.slot_dest[0], 0);
    chk("flush_slot1", dut.slot_dest[1], 31);
    chk("flush_cnt", stall_count, 4);

    bubbles();
    cyc(ADD3, 1'b1, 1'b0);
    cyc(SUB4, 1'b1, 1'b0);
    chk("mid_stall", stall_out, 1);
    reset = 1'b1;
    cyc(SUB4, 1'b1, 1'b0);
    reset = 1'b0;
    chk("mid_rst_stall", stall_out, 0);
    chk("mid_rst_cnt", stall_count, 0);
    chk("mid_rst_slot0", dut.slot_dest[0], 0);
    chk("mid_rst_slot1", dut.slot_dest[1], 0);
    cyc(SUB4, 1'b1, 1'b0);
    chk("post_rst_nostall", stall_out, 0);

    for (int n = 0; n < 9; n++) begin
      bubbles();
      cyc(ADD3, 1'b1, 1'b0);
      cyc(SUB4, 1'b1, 1'b0);
      cyc(SUB4, 1'b1, 1'b0);
      cyc(SUB4, 1'b1, 1'b0);
      if (n == 6) chk("sat_cnt14", stall_count, 14);
    end
    chk("sat_cnt15", stall_count, 15);
`else
    cyc(LW8, 1'b1, 1'b0);
    cyc(ADD10, 1'b1, 1'b0);
    chk("lu_stall", stall_out, 1);
    chk("lu_fwd_rs0", fwd_rs_sel, 0);
    cyc(ADD10, 1'b1, 1'b0);
    chk("lu_rel", stall_out, 0);
    chk("lu_fwd_rs", fwd_rs_sel, 2);
    chk("lu_fwd_rt", fwd_rt_sel, 2);
    chk("lu_cnt", stall_count, 1);

    bubbles();
    cyc(ADD3, 1'b1, 1'b0);
    cyc(BEQ34, 1'b1, 1'b0);
    chk("beq_stall", stall_out, 0);
    chk("beq_fwd_rs", fwd_rs_sel, 1);
    chk("beq_fwd_rt", fwd_rt_sel, 0);

    bubbles();
    cyc(ADD3, 1'b1, 1'b0);
    cyc(ADD3, 1'b1, 1'b0);
    cyc(BEQ34, 1'b1, 1'b0);
    chk("prio_fwd_rs", fwd_rs_sel, 1);

    bubbles();
    cyc(ADD3, 1'b1, 1'b0);
    cyc(32'd0, 1'b0, 1'b0);
    cyc(BEQ34, 1'b1, 1'b0);
    chk("old_fwd_rs", fwd_rs_sel, 2);

    bubbles();
    cyc(JAL, 1'b1, 1'b0);
    cyc(JR31, 1'b1, 1'b0);
    chk("jr_stall", stall_out, 0);
    chk("jr_fwd_rs", fwd_rs_sel, 1);

    bubbles();
    cyc(JAL, 1'b1, 1'b0);
    cyc(JR31, 1'b1, 1'b1);
    chk("flush_stall", stall_out, 0);
    chk("flush_fwd_rs", fwd_rs_sel, 0);
    chk("flush_slot0", dut.slot_dest[0], 0);

    bubbles();
    cyc(LW8, 1'b1, 1'b0);
    cyc(ADD10, 1'b1, 1'b0);
    chk("mid_stall", stall_out, 1);
    reset = 1'b1;
    cyc(ADD10, 1'b1, 1'b0);
    reset = 1'b0;
    chk("mid_rst_stall", stall_out, 0);
    chk("mid_rst_cnt", stall_count, 0);
    chk("mid_rst_slot0", dut.slot_dest[0], 0);
    chk("mid_rst_slot1", dut.slot_dest[1], 0);
    cyc(ADD10, 1'b1, 1'b0);
    chk("post_rst_nostall", stall_out, 0);
    chk("post_rst_fwd", fwd_rs_sel, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter DEPTH, default 2, number of in-flight writer slots tracked and compared (legal 1..8).
REQ-002 Parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instr_in  input  32  instruction in decode; opcode [31:26], rs [25:21], rt [20:16], rd [15:11].
REQ-006 instr_valid  input  1  instr_in holds a real instruction; low inserts a bubble.
REQ-007 flush  input  1  squash the instruction in decode this cycle.
REQ-008 stall_out  output  1  registered; decode must hold instr_in next cycle.
REQ-009 fwd_rs_sel  output  4  registered; forwarding source for rs: 0 = register file, k = slot k-1.
REQ-010 fwd_rt_sel  output  4  registered; forwarding source for rt, same encoding as fwd_rs_sel.
REQ-011 stall_count  output  CNT_W  saturating count of cycles with stall_out high.

Function
REQ-012 The block SHALL decode instr_in as follows:
- opcode[5:3]=001: read rs, write rt.
- opcode[5:3]=100 (load): read rs, write rt, load flag set.
- opcode[5:2]=1010 (store): read rs and rt.
- opcode[5:1]=00010: read rs and rt.
- opcode[5:1]=00011 or opcode=000001: read rs.
- opcode=000000: read rs and rt, write rd.
- opcode=000011: write register 31.
- Any other opcode: no reads, no writes.
REQ-013 The block SHALL keep DEPTH slots, each holding {dest[4:0], load}; slot 0 is the youngest.
REQ-014 Each non-reset cycle, slot k+1 SHALL take slot k, and slots SHALL drop off the end at DEPTH-1.
REQ-015 Slot 0 SHALL take the decoded dest and load flag only if instr_valid=1, flush=0 and the computed stall is 0; otherwise it SHALL take {0,0}.
REQ-016 A source operand SHALL match a slot when the operand is read, is nonzero, and equals that slot's dest.
- dest 0 never creates a hazard.
REQ-017 Stall SHALL be computed from the current slots and the current instr_in, and registered into stall_out (1-cycle latency).
- flush=1 or instr_valid=0 forces the registered stall to 0.
REQ-018 If rs and rt both match, the block SHALL stall if either operand requires a stall.
REQ-019 If several slots match one operand, the youngest (lowest index) SHALL take priority.
REQ-020 While stalled, the block SHALL accept a re-presented instruction unchanged; bubbles age out and the stall releases after at most DEPTH cycles.
REQ-021 stall_count SHALL increment by 1 on each cycle stall_out=1 and SHALL hold at all-ones.

Reset
REQ-022 On reset, all slots SHALL clear to {0,0}, and stall_out, fwd_rs_sel, fwd_rt_sel and stall_count SHALL clear to 0.
REQ-023 Reset SHALL take priority over all inputs, including mid-stall; the next cycle after reset release SHALL see no hazards.

Configuration
REQ-024 Macro HAZARD_FWD_EN selects the hazard mode:
- Defined: stall only when an operand matches slot 0 with load=1 (load-use).
- Defined: for a non-stalling match, fwd_*_sel = matched slot index + 1; otherwise 0.
- Undefined: stall on any match in any slot, and fwd_rs_sel and fwd_rt_sel are tied to 0.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Without HAZARD_FWD_EN, DEPTH=2: add $3,$1,$2 then sub $4,$3,$5 -> stall_out=1 for 2 cycles, then 0; stall_count=2.
- Without HAZARD_FWD_EN: addi $0,$1,5 then add $6,$0,$0 -> stall_out stays 0.
- With HAZARD_FWD_EN: lw $8,0($9) then add $10,$8,$8 -> stall_out=1 for 1 cycle, then fwd_rs_sel=2 and fwd_rt_sel=2.
- With HAZARD_FWD_EN: add $3,$1,$2 then beq $3,$4 -> stall_out=0 and fwd_rs_sel=1.
- jal then jr $31 -> stall without HAZARD_FWD_EN; with flush=1 on the jr cycle -> stall_out=0 and slot 0 cleared.
- Assert reset during a stall -> the next cycle has stall_out=0, stall_count=0 and all slots empty.
